// File: rtl/i2c_pkg.sv
// Shared types and constants for the burst I2C master.
// Optional feature macro: I2C_CLK_STRETCH_EN.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    STOP
  } i2c_state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-bit prescaler for the I2C master.
// I2C_CLK_STRETCH_EN freezes q2 while a slave holds SCL low.
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       scl_rel,
  input  logic       scl_i,
  output logic [1:0] q,
  output logic       q_first,
  output logic       q_last
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          hold;

`ifdef I2C_CLK_STRETCH_EN
  // Only stretch once our own release has reached the pad.
  assign hold = (q == Q2) && scl_rel && !scl_i;
`else
  logic unused_pins;
  assign unused_pins = scl_rel ^ scl_i;
  assign hold = 1'b0;
`endif

  assign q_first = (cnt == '0);
  assign q_last  = (cnt == CW'(CLK_DIV - 1)) && !hold;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
      q   <= Q0;
    end else if (q_last) begin
      cnt <= '0;
      q   <= q + 2'd1;
    end else if (!hold) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_burst_master.sv
// Single-master I2C controller: START, address, 0..MAX_LEN bytes, STOP.
// Optional slave clock stretching under I2C_CLK_STRETCH_EN.
module i2c_burst_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             nack_err,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             scl_i,
  input  logic             sda_i
);

  i2c_state_t       state, nxt;
  logic [1:0]       q;
  logic             q_first, q_last;
  logic [2:0]       bit_cnt;
  logic [LEN_W-1:0] left;
  logic [7:0]       shreg;
  logic             rw_q, ack, stop_end;
  logic             scl_d, sda_d, bit_tx;
  logic             slot_end, sample, load, accept;

  i2c_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (state != IDLE),
    .scl_rel(!scl_oe),
    .scl_i  (scl_i),
    .q      (q),
    .q_first(q_first),
    .q_last (q_last)
  );

  assign slot_end = (q == Q3) && q_last;
  assign sample   = (q == Q2) && q_last;
  assign load     = (state == WR_BYTE) && (bit_cnt == 3'd0)
                 && (q == Q0) && q_first;
  assign accept   = (state == IDLE) && start && !busy && !done;
  // The byte is latched this cycle, so its MSB comes straight from the port.
  assign bit_tx   = load ? wr_data[7] : shreg[7];

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (accept) nxt = START;
      START:    if (slot_end) nxt = ADDR;
      ADDR:     if (slot_end && bit_cnt == 3'd7) nxt = ADDR_ACK;
      ADDR_ACK: if (slot_end) begin
        if (ack == I2C_NACK || left == '0) nxt = STOP;
        else if (rw_q) nxt = RD_BYTE;
        else nxt = WR_BYTE;
      end
      WR_BYTE:  if (slot_end && bit_cnt == 3'd7) nxt = WR_ACK;
      WR_ACK:   if (slot_end) begin
        if (ack == I2C_NACK || left == LEN_W'(1)) nxt = STOP;
        else nxt = WR_BYTE;
      end
      RD_BYTE:  if (slot_end && bit_cnt == 3'd7) nxt = RD_ACK;
      RD_ACK:   if (slot_end) begin
        if (left == LEN_W'(1)) nxt = STOP;
        else nxt = RD_BYTE;
      end
      STOP:     if (slot_end) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_comb begin
    scl_d = 1'b0;
    sda_d = 1'b0;
    case (state)
      IDLE: ;
      START: sda_d = q[1];
      STOP: begin
        scl_d = !q[1];
        sda_d = (q != Q3);
      end
      ADDR, WR_BYTE: begin
        scl_d = !q[1];
        sda_d = !bit_tx;
      end
      RD_ACK: begin
        scl_d = !q[1];
        sda_d = (left != LEN_W'(1));
      end
      default: scl_d = !q[1];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      stop_end <= 1'b0;
      nack_err <= 1'b0;
      rd_valid <= 1'b0;
      wr_ready <= 1'b0;
      rd_data  <= 8'h00;
      bit_cnt  <= 3'd0;
      left     <= '0;
      shreg    <= 8'h00;
      rw_q     <= 1'b0;
      ack      <= 1'b0;
    end else begin
      state    <= nxt;
      scl_oe   <= scl_d;
      sda_oe   <= sda_d;
      rd_valid <= 1'b0;
      stop_end <= (state == STOP) && slot_end;
      done     <= stop_end;
      busy     <= (nxt != IDLE) || ((state == STOP) && slot_end);
      wr_ready <= (nxt == WR_BYTE) && (state != WR_BYTE);
      if (accept) begin
        nack_err <= 1'b0;
        rw_q     <= rw;
        shreg    <= {addr, rw};
        bit_cnt  <= 3'd0;
        left     <= (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
      end
      if (load) shreg <= wr_data;
      if (sample) begin
        ack <= sda_i;
        if (state == RD_BYTE) begin
          shreg <= {shreg[6:0], sda_i};
          if (bit_cnt == 3'd7) begin
            rd_data  <= {shreg[6:0], sda_i};
            rd_valid <= 1'b1;
          end
        end
      end
      if (slot_end) begin
        unique case (1'b1)
          state == ADDR, state == WR_BYTE: begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          state == RD_BYTE: bit_cnt <= bit_cnt + 3'd1;
          state == ADDR_ACK: if (ack == I2C_NACK) nack_err <= 1'b1;
          state == WR_ACK: begin
            if (ack == I2C_NACK) nack_err <= 1'b1;
            else left <= left - LEN_W'(1);
          end
          state == RD_ACK: left <= left - LEN_W'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_burst_master.sv
// Bench for i2c_burst_master with a behavioural pull-up slave.
// Stretch scenario is built when I2C_CLK_STRETCH_EN is defined.
module tb_i2c_burst_master;

  localparam int CLK_DIV = 4;
  localparam int MAX_LEN = 4;
  localparam int LEN_W   = 3;
  localparam int QB      = 4 * CLK_DIV;
  localparam int LIMIT   = 2000;
  localparam logic [6:0] SLV = 7'h50;

  logic clk = 1'b0;
  logic rst, start, rw;
  logic [6:0] addr;
  logic [LEN_W-1:0] len;
  logic [7:0] wr_data, rd_data;
  logic wr_ready, rd_valid, busy, done, nack_err;
  logic scl_oe, sda_oe, scl_i, sda_i;
  logic s_sda_low, s_scl_low;

  int tests = 0;
  int fails = 0;

  logic [7:0] bus_q[$];
  logic [7:0] rd_src[$];
  logic [7:0] rd_got[$];
  logic [7:0] wq[$];
  bit         mack_q[$];
  int nack_at = 0;
  int stretch_n = 0;
  int wr_cnt;

  // slave model state
  int ph, bitn, wcount, stretch_left;
  logic [7:0] sh, txb;
  bit in_addr, rmode, nacked;
  logic pscl, psda, cs, cd;

  assign scl_i = ~scl_oe & ~s_scl_low;
  assign sda_i = ~sda_oe & ~s_sda_low;

  always #5 clk = ~clk;

  i2c_burst_master #(
    .CLK_DIV(CLK_DIV),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rw      (rw),
    .addr    (addr),
    .len     (len),
    .wr_data (wr_data),
    .wr_ready(wr_ready),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .busy    (busy),
    .done    (done),
    .nack_err(nack_err),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .scl_i   (scl_i),
    .sda_i   (sda_i)
  );

  // Slave: ph 0 idle, 1 receive, 2 own ack, 3 transmit, 4 master ack, 5 ignore
  initial begin
    s_sda_low = 0; s_scl_low = 0; ph = 0; pscl = 1; psda = 1;
    bitn = 0; wcount = 0; stretch_left = 0; sh = 0; txb = 0;
    in_addr = 0; rmode = 0; nacked = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ph = 0; s_sda_low = 0; s_scl_low = 0; pscl = 1; psda = 1;
      end else begin
        if (s_scl_low) begin
          if (!scl_oe) stretch_left--;
          if (stretch_left <= 0) s_scl_low = 0;
        end
        cs = ~scl_oe & ~s_scl_low;
        cd = ~sda_oe & ~s_sda_low;
        if (pscl && cs && psda && !cd) begin
          ph = 1; bitn = 0; in_addr = 1; wcount = 0; nacked = 0;
        end else if (pscl && cs && !psda && cd) begin
          ph = 0;
        end else if (!pscl && cs) begin
          if (ph == 1) begin sh = {sh[6:0], cd}; bitn++; end
          else if (ph == 3) bitn++;
          else if (ph == 4) begin
            mack_q.push_back(cd);
            if (cd) ph = 0;
          end
        end else if (pscl && !cs) begin
          case (ph)
            1: if (bitn == 8) begin
              bus_q.push_back(sh);
              bitn = 0;
              if (in_addr) begin
                if (sh[7:1] == SLV) begin
                  rmode = sh[0]; s_sda_low = 1; ph = 2;
                end else ph = 5;
              end else begin
                wcount++;
                nacked = (wcount == nack_at);
                s_sda_low = !nacked;
                ph = 2;
              end
            end
            2: begin
              s_sda_low = 0;
              if (in_addr && stretch_n > 0) begin
                s_scl_low = 1; stretch_left = stretch_n;
              end
              if (nacked) ph = 5;
              else if (in_addr && rmode) begin
                txb = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hFF;
                s_sda_low = ~txb[7]; bitn = 0; ph = 3;
              end else begin
                ph = 1; bitn = 0;
              end
              in_addr = 0;
            end
            3: if (bitn == 8) begin
              s_sda_low = 0; ph = 4;
            end else s_sda_low = ~txb[7-bitn];
            4: begin
              txb = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hFF;
              s_sda_low = ~txb[7]; bitn = 0; ph = 3;
            end
            default: ;
          endcase
        end
        pscl = cs;
        psda = ~sda_oe & ~s_sda_low;
      end
    end
  end

  task automatic run_txn(input bit r, input logic [6:0] a,
                         input logic [LEN_W-1:0] l,
                         output int cyc, output bit to);
    @(negedge clk);
    start = 1; rw = r; addr = a; len = l;
    wr_cnt = 0; rd_got.delete(); mack_q.delete(); bus_q.delete();
    to = 1;
    for (cyc = 1; cyc <= LIMIT; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 0;
      if (cyc == 50) begin start = 1; addr = 7'h12; end
      if (cyc == 51) start = 0;
      if (wr_ready) begin
        wr_cnt++;
        wr_data = (wq.size() > 0) ? wq.pop_front() : 8'h00;
      end
      if (rd_valid) rd_got.push_back(rd_data);
      if (done) begin to = 0; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; rw = 0; addr = 0; len = 0; wr_data = 0;
    repeat (3) @(negedge clk);
    tests++;
    if ({scl_oe, sda_oe, busy, done, nack_err, rd_valid, wr_ready} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctl got %b want 0000000",
               {scl_oe, sda_oe, busy, done, nack_err, rd_valid, wr_ready});
    end
    tests++;
    if (rd_data !== 8'h00) begin
      fails++; $display("FAIL reset_rd_data got %h want 00", rd_data);
    end
    rst = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    logic [7:0] data[$];
    logic [7:0] exp;
    logic [LEN_W-1:0] l;
    int cyc, n;
    bit to;
    for (int it = 0; it < 4; it++) begin
      data.delete();
      l = (it == 0) ? 3'd2 : (it == 3) ? 3'd7 : 3'($urandom_range(1, 6));
      n = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
      for (int i = 0; i < n; i++)
        data.push_back(it == 0 ? (i == 0 ? 8'hA5 : 8'h3C) : 8'($urandom));
      wq = data;
      run_txn(1'b0, SLV, l, cyc, to);
      tests++;
      if (to || cyc != (11 + 9 * n) * QB + 2) begin
        fails++;
        $display("FAIL write_time len=%0d got %0d want %0d", l, cyc, (11 + 9 * n) * QB + 2);
      end
      tests++;
      if (nack_err !== 1'b0) begin
        fails++; $display("FAIL write_nack got %b want 0", nack_err);
      end
      tests++;
      if (wr_cnt != n) begin
        fails++; $display("FAIL write_ready got %0d want %0d", wr_cnt, n);
      end
      tests++;
      if (bus_q.size() != n + 1) begin
        fails++; $display("FAIL write_bus_len got %0d want %0d", bus_q.size(), n + 1);
      end else begin
        for (int i = 0; i <= n; i++) begin
          exp = (i == 0) ? {SLV, 1'b0} : data[i-1];
          tests++;
          if (bus_q[i] !== exp) begin
            fails++; $display("FAIL write_byte%0d got %h want %h", i, bus_q[i], exp);
          end
        end
      end
    end
  endtask

  task automatic test_read();
    logic [7:0] data[$];
    logic [LEN_W-1:0] l;
    int cyc, n;
    bit to;
    for (int it = 0; it < 3; it++) begin
      data.delete();
      l = (it == 0) ? 3'd3 : (it == 2) ? 3'd7 : 3'($urandom_range(1, 6));
      n = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
      for (int i = 0; i < n; i++)
        data.push_back(it == 0 ? 8'(8'h11 * (i + 1)) : 8'($urandom));
      rd_src = data;
      run_txn(1'b1, SLV, l, cyc, to);
      tests++;
      if (to || cyc != (11 + 9 * n) * QB + 2) begin
        fails++;
        $display("FAIL read_time got %0d want %0d", cyc, (11 + 9 * n) * QB + 2);
      end
      tests++;
      if (bus_q.size() != 1 || bus_q[0] !== {SLV, 1'b1}) begin
        fails++; $display("FAIL read_addr got %0d bytes, first %h want A1",
                          bus_q.size(), bus_q.size() > 0 ? bus_q[0] : 8'h00);
      end
      tests++;
      if (rd_got.size() != n) begin
        fails++; $display("FAIL read_count got %0d want %0d", rd_got.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          tests++;
          if (rd_got[i] !== data[i]) begin
            fails++; $display("FAIL read_byte%0d got %h want %h", i, rd_got[i], data[i]);
          end
        end
      end
      tests++;
      if (mack_q.size() != n) begin
        fails++; $display("FAIL read_mack_count got %0d want %0d", mack_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          tests++;
          if (mack_q[i] != (i == n - 1)) begin
            fails++; $display("FAIL read_mack%0d got %b want %b", i, mack_q[i], i == n - 1);
          end
        end
      end
    end
  endtask

  task automatic test_nack_addr();
    int cyc;
    bit to;
    wq.delete();
    wq.push_back(8'h5A); wq.push_back(8'h77);
    run_txn(1'b0, 7'h12, 3'd2, cyc, to);
    tests++;
    if (to || cyc != 11 * QB + 2) begin
      fails++; $display("FAIL nack_addr_time got %0d want %0d", cyc, 11 * QB + 2);
    end
    tests++;
    if (nack_err !== 1'b1) begin
      fails++; $display("FAIL nack_addr_err got %b want 1", nack_err);
    end
    tests++;
    if (wr_cnt != 0) begin
      fails++; $display("FAIL nack_addr_ready got %0d want 0", wr_cnt);
    end
  endtask

  task automatic test_nack_data();
    int cyc;
    bit to;
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(8'($urandom));
    nack_at = 2;
    run_txn(1'b0, SLV, 3'd4, cyc, to);
    nack_at = 0;
    tests++;
    if (to || cyc != (11 + 18) * QB + 2) begin
      fails++; $display("FAIL nack_data_time got %0d want %0d", cyc, 29 * QB + 2);
    end
    tests++;
    if (nack_err !== 1'b1) begin
      fails++; $display("FAIL nack_data_err got %b want 1", nack_err);
    end
    tests++;
    if (wr_cnt != 2 || bus_q.size() != 3) begin
      fails++; $display("FAIL nack_data_bytes got %0d/%0d want 2/3", wr_cnt, bus_q.size());
    end
  endtask

  task automatic test_probe();
    int cyc;
    bit to;
    run_txn(1'b0, SLV, 3'd0, cyc, to);
    tests++;
    if (to || cyc != 11 * QB + 2) begin
      fails++; $display("FAIL probe_time got %0d want %0d", cyc, 11 * QB + 2);
    end
    tests++;
    if (nack_err !== 1'b0 || bus_q.size() != 1 || bus_q[0] !== 8'hA0) begin
      fails++; $display("FAIL probe_result got nack=%b bytes=%0d want nack=0 bytes=1 A0",
                        nack_err, bus_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit to;
    wq.delete();
    wq.push_back(8'hC3); wq.push_back(8'h81);
    @(negedge clk);
    start = 1; rw = 0; addr = SLV; len = 3'd2;
    for (int c = 1; c <= 1 + 11 * QB + 6; c++) begin
      @(negedge clk);
      if (c == 1) start = 0;
      if (wr_ready) wr_data = (wq.size() > 0) ? wq.pop_front() : 8'h00;
    end
    rst = 1;
    @(negedge clk);
    tests++;
    if ({scl_oe, sda_oe, busy} !== 3'b000) begin
      fails++; $display("FAIL reset_mid got scl/sda/busy=%b want 000", {scl_oe, sda_oe, busy});
    end
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    wq.delete();
    wq.push_back(8'h96);
    run_txn(1'b0, SLV, 3'd1, cyc, to);
    tests++;
    if (to || cyc != 20 * QB + 2 || bus_q.size() != 2 || bus_q[1] !== 8'h96) begin
      fails++; $display("FAIL reset_mid_rerun got cyc=%0d bytes=%0d want cyc=%0d bytes=2",
                        cyc, bus_q.size(), 20 * QB + 2);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit to;
    run_txn(1'b0, SLV, 3'd0, cyc, to);
    start = 1; rw = 0; addr = SLV; len = 3'd0;
    @(negedge clk);
    start = 0;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL b2b_start_on_done got busy=%b want 0", busy);
    end
    wq.delete();
    wq.push_back(8'h3E);
    run_txn(1'b0, SLV, 3'd1, cyc, to);
    tests++;
    if (to || cyc != 20 * QB + 2 || wr_cnt != 1) begin
      fails++; $display("FAIL b2b_second got cyc=%0d wr=%0d want cyc=%0d wr=1",
                        cyc, wr_cnt, 20 * QB + 2);
    end
  endtask

`ifdef I2C_CLK_STRETCH_EN
  task automatic test_stretch();
    int cyc;
    bit to;
    wq.delete();
    wq.push_back(8'hA5); wq.push_back(8'h3C);
    stretch_n = 40;
    run_txn(1'b0, SLV, 3'd2, cyc, to);
    stretch_n = 0;
    tests++;
    if (to || cyc != 29 * QB + 2 + 40) begin
      fails++; $display("FAIL stretch_time got %0d want %0d", cyc, 29 * QB + 2 + 40);
    end
    tests++;
    if (bus_q.size() != 3 || bus_q[1] !== 8'hA5 || bus_q[2] !== 8'h3C) begin
      fails++; $display("FAIL stretch_bytes got %0d bytes want A0 A5 3C", bus_q.size());
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack_addr();
    test_nack_data();
    test_probe();
    test_reset_mid();
    test_back_to_back();
`ifdef I2C_CLK_STRETCH_EN
    test_stretch();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
